flopoco_ieee_encode: RTL and testbench

- Streaming converter from packed IEEE-style floats {sign, biased exp, fraction} to the FloPoCo internal format {exc[1:0], sign, exp, frac}.
- This is the producer side of the FloPoCo operand interface. Its output word feeds fcmplt and the other FloPoCo operators directly.
- Two-stage pipeline with valid/ready handshake on both sides.
- Carries saturating counters for NaN inputs and flushed subnormals, for debug and accuracy monitoring.

---
 rtl/flopoco_ieee_encode.sv | 165 ++++++++++++++++
 tb/tb_flopoco_ieee_encode.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flopoco_ieee_encode.sv
// flopoco_ieee_encode
//   Converts packed IEEE-style floats {sign, biased exp, frac} into the FloPoCo
//   internal operand format {exc[1:0], sign, exp, frac}. There are two
//   registered stages with a valid/ready handshake on both sides. Saturating
//   counters track accepted NaNs and subnormals that were flushed to zero.
//
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     in_valid/in_ready     input handshake; a word is accepted when both are high
//     in_data[WE+WF:0]      {sign, exp[WE-1:0], frac[WF-1:0]}
//     out_valid/out_ready   output handshake
//     out_data[WE+WF+2:0]   {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}
//     nan_cnt, flush_cnt    saturating status counters, bumped on input accept
//     clr_cnt               synchronous clear of both counters (beats an increment)
module flopoco_ieee_encode #(
    parameter int WE      = 4,
    parameter int WF      = 4,
    parameter int SUBNORM = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WE+WF:0]       in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WE+WF+2:0]     out_data,
    output logic [CNT_W-1:0]     nan_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    input  logic                 clr_cnt
);
    localparam int LZ_W = $clog2(WF + 1);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM,
        CLS_SUB
    } cls_t;

    // Leading-zero count of the fraction, scanning from the MSB.
    function automatic logic [LZ_W-1:0] count_lz(input logic [WF-1:0] f);
        logic [LZ_W-1:0] n;
        logic            done;
        n    = '0;
        done = 1'b0;
        for (int i = WF - 1; i >= 0; i--) begin
            if (!done) begin
                if (f[i]) done = 1'b1;
                else      n    = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- input decode
    logic          in_sign;
    logic [WE-1:0] in_exp;
    logic [WF-1:0] in_frac;
    logic          exp_ones, exp_zero, frac_zero;
    logic          in_nan, in_flush;
    cls_t          in_cls;

    assign in_sign   = in_data[WE+WF];
    assign in_exp    = in_data[WF +: WE];
    assign in_frac   = in_data[WF-1:0];
    assign exp_ones  = &in_exp;
    assign exp_zero  = ~|in_exp;
    assign frac_zero = ~|in_frac;
    assign in_nan    = exp_ones & ~frac_zero;
    // A subnormal survives only when normalization is enabled and its
    // fraction MSB is set (lz == 0); every other subnormal becomes zero.
    assign in_flush  = exp_zero & ~frac_zero & ~((SUBNORM != 0) & in_frac[WF-1]);

    always_comb begin
        in_cls = CLS_NORM;
        if (exp_zero)      in_cls = frac_zero ? CLS_ZERO : CLS_SUB;
        else if (exp_ones) in_cls = frac_zero ? CLS_INF  : CLS_NAN;
    end

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic s2_load, s1_load, accept;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid & in_ready;

    // ---------------------------------------------------------------- stage 1
    cls_t            s1_cls;
    logic            s1_sign;
    logic [WE-1:0]   s1_exp;
    logic [WF-1:0]   s1_frac;
    logic [LZ_W-1:0] s1_lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_lz    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cls  <= in_cls;
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_frac <= in_frac;
                s1_lz   <= count_lz(in_frac);
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [WE+WF+2:0] fmt;

    always_comb begin
        fmt = '0;
        unique case (s1_cls)
            CLS_ZERO: fmt = {2'b00, s1_sign, {WE{1'b0}}, {WF{1'b0}}};
            CLS_INF:  fmt = {2'b10, s1_sign, {WE{1'b0}}, {WF{1'b0}}};
            CLS_NAN:  fmt = {2'b11, 1'b0,    {WE{1'b0}}, {WF{1'b0}}};
            CLS_NORM: fmt = {2'b01, s1_sign, s1_exp, s1_frac};
            CLS_SUB: begin
                if ((SUBNORM != 0) && (s1_lz == '0))
                    fmt = {2'b01, s1_sign, {WE{1'b0}}, s1_frac[WF-2:0], 1'b0};
                else
                    fmt = {2'b00, s1_sign, {WE{1'b0}}, {WF{1'b0}}};
            end
            default:  fmt = '0;
        endcase
    end

    // out_data only changes when a new word moves in, so it stays stable
    // through a stall and keeps the last word once the pipe drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= fmt;
        end
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_cnt   <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            nan_cnt   <= '0;
            flush_cnt <= '0;
        end else if (accept) begin
            if (in_nan && nan_cnt != '1)     nan_cnt   <= nan_cnt + CNT_W'(1);
            if (in_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_flopoco_ieee_encode.sv
module tb_flopoco_ieee_encode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        out_ready = 1'b1;
  logic        clr_cnt = 1'b0;

  // a: SUBNORM=1, CNT_W=16   b: SUBNORM=0, CNT_W=2 (same stimulus)
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [10:0] out_data_a, out_data_b;
  logic [15:0] nan_a, flush_a;
  logic [1:0]  nan_b, flush_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flopoco_ieee_encode #(.WE(4), .WF(4), .SUBNORM(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .nan_cnt(nan_a), .flush_cnt(flush_a), .clr_cnt(clr_cnt));

  flopoco_ieee_encode #(.WE(4), .WF(4), .SUBNORM(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .nan_cnt(nan_b), .flush_cnt(flush_b), .clr_cnt(clr_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [10:0] enc(input logic [8:0] d, input bit sub);
    int s, e, f, r;
    s = int'(d[8]); e = int'(d[7:4]); f = int'(d[3:0]);
    if (e == 15)               r = (f != 0) ? 'h600 : ('h400 + s * 256);
    else if (e == 0 && f == 0) r = s * 256;
    else if (e == 0)           r = (sub && f >= 8) ? ('h200 + s * 256 + (f * 2) % 16) : s * 256;
    else                       r = 'h200 + s * 256 + e * 16 + f;
    return 11'(r);
  endfunction

  function automatic bit is_nan(input logic [8:0] d);
    return (d[7:4] == 4'hF) && (d[3:0] != 0);
  endfunction

  function automatic bit is_flush(input logic [8:0] d, input bit sub);
    return (d[7:4] == 0) && (d[3:0] != 0) && !(sub && d[3:0] >= 8);
  endfunction

  typedef struct {
    logic [10:0] a;
    logic [10:0] b;
    int          t;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    m_nan_a = 0, m_flush_a = 0, m_nan_b = 0, m_flush_b = 0;
  bit    seen = 0;

  // A word accepted in cycle c is visible from cycle c+2 onward, one at a time.
  function automatic bit m_ov();
    return (q.size() > 0) && (q[0].t <= cyc);
  endfunction

  function automatic bit m_ir();
    int held_back;
    held_back = q.size() - (m_ov() ? 1 : 0);
    return (held_back == 0) || !m_ov() || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_nan_a = 0; m_flush_a = 0; m_nan_b = 0; m_flush_b = 0;
      seen = 0;
    end else begin
      bit acc, pop;
      acc = in_valid && m_ir();
      pop = m_ov() && out_ready;
      if (m_ov()) seen = 1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{a: enc(in_data, 1), b: enc(in_data, 0), t: cyc + 2});
      if (clr_cnt) begin
        m_nan_a = 0; m_flush_a = 0; m_nan_b = 0; m_flush_b = 0;
      end else if (acc) begin
        if (is_nan(in_data)) begin
          if (m_nan_a < 65535) m_nan_a++;
          if (m_nan_b < 3)     m_nan_b++;
        end
        if (is_flush(in_data, 1) && m_flush_a < 65535) m_flush_a++;
        if (is_flush(in_data, 0) && m_flush_b < 3)     m_flush_b++;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_valid_a", 32'(out_valid_a), 32'(m_ov()));
      chk("cmp_valid_b", 32'(out_valid_b), 32'(m_ov()));
      chk("cmp_ready_a", 32'(in_ready_a), 32'(m_ir()));
      chk("cmp_ready_b", 32'(in_ready_b), 32'(m_ir()));
      if (m_ov()) begin
        chk("cmp_data_a", 32'(out_data_a), 32'(q[0].a));
        chk("cmp_data_b", 32'(out_data_b), 32'(q[0].b));
      end else if (!seen) begin
        chk("cmp_idle_a", 32'(out_data_a), 0);
        chk("cmp_idle_b", 32'(out_data_b), 0);
      end
      chk("cmp_nan_a",   32'(nan_a),   32'(m_nan_a));
      chk("cmp_flush_a", 32'(flush_a), 32'(m_flush_a));
      chk("cmp_nan_b",   32'(nan_b),   32'(m_nan_b));
      chk("cmp_flush_b", 32'(flush_b), 32'(m_flush_b));
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push(input logic [8:0] d);
    bit acc;
    acc = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout data=%0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic one(input logic [8:0] d, input logic [10:0] ea, input logic [10:0] eb);
    push(d);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", 32'(out_valid_a), 0);
    @(negedge clk);
    chk("lat2_valid", 32'(out_valid_a), 1);
    chk("lit_data_a", 32'(out_data_a), 32'(ea));
    chk("lit_data_b", 32'(out_data_b), 32'(eb));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #22 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_a), 0);
    chk("rst_data",  32'(out_data_a), 0);
    chk("rst_ready", 32'(in_ready_a), 1);
    chk("rst_nan",   32'(nan_a), 0);
    @(posedge clk); #1;

    // normals and specials
    one(9'h070, 11'h270, 11'h270);
    one(9'h17F, 11'h37F, 11'h37F);
    one(9'h1F0, 11'h500, 11'h500);
    one(9'h0F5, 11'h600, 11'h600);
    chk("nan_a_1", 32'(nan_a), 1);
    chk("nan_b_1", 32'(nan_b), 1);
    one(9'h100, 11'h100, 11'h100);
    one(9'h000, 11'h000, 11'h000);

    // subnormals: a normalizes lz=0, b flushes everything
    one(9'h00A, 11'h204, 11'h000);
    chk("flush_a_0", 32'(flush_a), 0);
    chk("flush_b_1", 32'(flush_b), 1);
    one(9'h003, 11'h000, 11'h000);
    chk("flush_a_1", 32'(flush_a), 1);
    one(9'h102, 11'h100, 11'h100);
    chk("flush_a_2", 32'(flush_a), 2);
    chk("flush_b_3", 32'(flush_b), 3);

    // backpressure
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) push(9'h070 + 9'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_full_ready", 32'(in_ready_a), 0);
        chk("bp_valid",      32'(out_valid_a), 1);
        chk("bp_data",       32'(out_data_a), 'h270);
        repeat (2) @(negedge clk);
        chk("bp_hold_data",  32'(out_data_a), 'h270);
        chk("bp_hold_ready", 32'(in_ready_a), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_drain_valid", 32'(out_valid_a), 1);
          chk("bp_drain_data",  32'(out_data_a), 32'('h270 + i));
        end
      end
    join
    @(posedge clk); #1;

    // counters: clear, count, clear beats increment, saturation
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_nan_a",   32'(nan_a), 0);
    chk("clr_flush_b", 32'(flush_b), 0);
    repeat (3) one(9'h0F5, 11'h600, 11'h600);
    chk("nan_a_3", 32'(nan_a), 3);
    chk("nan_b_3", 32'(nan_b), 3);
    clr_cnt = 1'b1;
    push(9'h0F5);
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    chk("clr_win_a", 32'(nan_a), 0);
    chk("clr_win_b", 32'(nan_b), 0);
    repeat (3) @(posedge clk);
    #1;
    repeat (5) one(9'h0F5, 11'h600, 11'h600);
    chk("nan_a_5",   32'(nan_a), 5);
    chk("nan_b_sat", 32'(nan_b), 3);

    // reset with both stages full
    out_ready = 1'b0;
    push(9'h070);
    push(9'h071);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_ready", 32'(in_ready_a), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid_a), 0);
    chk("arst_data",  32'(out_data_a), 0);
    chk("arst_nan_a", 32'(nan_a), 0);
    chk("arst_nan_b", 32'(nan_b), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    one(9'h070, 11'h270, 11'h270);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid_a), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
